// File: rtl/alu_pkg.sv
// Shared constants and the issue-entry record for the ALU issue stage:
// ALU control codes, RV32I opcodes, funct7 values and the skid FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  control;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  br_funct;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } issue_entry_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/alu_imm_gen.sv
// Combinational RV32I immediate generator; the format (I/S/B/U/J) follows the opcode.
module alu_imm_gen
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU. Default is a 1-entry output register;
// defining ALU_ISSUE_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_control,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_br_funct,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic            out_illegal
);

    logic [31:0]  imm;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         bad;
    issue_entry_t dec;
    issue_entry_t head;

    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    alu_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    always_comb begin
        bad           = 1'b0;
        dec           = '0;
        dec.pc        = in_pc;
        dec.rs2       = rs2_data;
        dec.imm       = imm;
        dec.rd        = in_instr[11:7];
        dec.control   = ALU_ADD;
        case (in_instr[6:0])
            OPC_OP: begin
                bad = !(funct7 == F7_ZERO ||
                        (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
                dec.control = {funct7[5], funct3};
                dec.in1     = rs1_data;
                dec.in2     = rs2_data;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001)
                    bad = (funct7 != F7_ZERO);
                else if (funct3 == 3'b101)
                    bad = !(funct7 == F7_ZERO || funct7 == F7_ALT);
                dec.control = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : {1'b0, funct3};
                dec.in1     = rs1_data;
                // Shifts carry only the shamt; funct7 is not part of the operand.
                dec.in2     = (funct3 == 3'b001 || funct3 == 3'b101) ?
                              {27'b0, in_instr[24:20]} : imm;
            end
            OPC_LOAD, OPC_STORE: begin
                dec.in1 = rs1_data;
                dec.in2 = imm;
                if (in_instr[6:0] == OPC_STORE)
                    dec.rd = '0;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: dec.control = ALU_SUB;
                    3'b100, 3'b101: dec.control = ALU_SLT;
                    3'b110, 3'b111: dec.control = ALU_SLTU;
                    default:        bad = 1'b1;
                endcase
                dec.in1       = rs1_data;
                dec.in2       = rs2_data;
                dec.rd        = '0;
                dec.br_funct  = funct3;
                dec.is_branch = 1'b1;
            end
            OPC_LUI: begin
                dec.in2 = imm;
            end
            OPC_AUIPC: begin
                dec.in1 = in_pc;
                dec.in2 = imm;
            end
            OPC_JAL, OPC_JALR: begin
                dec.in1     = in_pc;
                dec.in2     = 32'd4;
                dec.is_jump = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // Illegal entries still issue so execute can trap; everything but pc/rs2 is zeroed.
        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.rs2     = rs2_data;
            dec.illegal = 1'b1;
        end
    end

`ifdef ALU_ISSUE_SKID_EN
    skid_state_t  state;
    issue_entry_t tail;
    logic         ready_q;
    logic         in_fire;
    logic         out_fire;

    assign in_ready  = ready_q;
    assign out_valid = (state != SKID_EMPTY);
    assign in_fire   = in_valid && ready_q;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SKID_EMPTY;
            head    <= '0;
            tail    <= '0;
            ready_q <= 1'b0;
        end else if (flush) begin
            state   <= SKID_EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        head  <= dec;
                        state <= SKID_ONE;
                    end
                    ready_q <= 1'b1;
                end
                SKID_ONE: begin
                    if (in_fire && !out_fire) begin
                        tail    <= dec;
                        state   <= SKID_FULL;
                        ready_q <= 1'b0;
                    end else if (out_fire && !in_fire) begin
                        state   <= SKID_EMPTY;
                        ready_q <= 1'b1;
                    end else begin
                        if (in_fire)
                            head <= dec;
                        ready_q <= 1'b1;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        head    <= tail;
                        state   <= SKID_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= SKID_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    logic valid_q;

    assign out_valid = valid_q;
    assign in_ready  = !valid_q || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            head    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid)
                head <= dec;
        end
    end
`endif

    // Empty stage presents zeros and the reset PC tag.
    assign out_control   = out_valid ? head.control   : '0;
    assign out_in1       = out_valid ? head.in1       : '0;
    assign out_in2       = out_valid ? head.in2       : '0;
    assign out_rs2       = out_valid ? head.rs2       : '0;
    assign out_imm       = out_valid ? head.imm       : '0;
    assign out_pc        = out_valid ? head.pc        : RESET_PC_TAG;
    assign out_rd        = out_valid ? head.rd        : '0;
    assign out_br_funct  = out_valid ? head.br_funct  : '0;
    assign out_is_branch = out_valid && head.is_branch;
    assign out_is_jump   = out_valid && head.is_jump;
    assign out_illegal   = out_valid && head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode vector table, then backpressure, flush and reset sequences.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_control;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [31:0] out_rs2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [2:0]  out_br_funct;
    logic        out_is_branch;
    logic        out_is_jump;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    alu_issue_stage #(.XLEN(32), .RESET_PC_TAG(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_control   (out_control),
        .out_in1       (out_in1),
        .out_in2       (out_in2),
        .out_rs2       (out_rs2),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_br_funct  (out_br_funct),
        .out_is_branch (out_is_branch),
        .out_is_jump   (out_is_jump),
        .out_illegal   (out_illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  control;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  br_funct;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi_instr(input int k);
        logic [31:0] kk;
        kk = k;
        return (kk << 20) | (kk << 7) | 32'h00000013;
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0;
        in_instr = 32'h0;
        in_pc    = 32'h0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
    endtask

    task automatic drive_instr(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    initial begin
        int sent;
        int popped;
        bit fire_in;
        bit fire_out;
        logic [31:0] exp_v;

        vecs[0]  = '{32'h002081B3, 32'h1000, 32'd5,        32'd7,        4'h0, 32'd5,        32'd7,        32'h0,        5'd3, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h402081B3, 32'h1004, 32'd10,       32'd3,        4'h8, 32'd10,       32'd3,        32'h0,        5'd3, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h022081B3, 32'h1008, 32'd10,       32'd3,        4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h40335293, 32'h100C, 32'h80000000, 32'h0,        4'hD, 32'h80000000, 32'd3,        32'h403,      5'd5, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'hFFF00093, 32'h1010, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h123453B7, 32'h1014, 32'h1111,     32'h2222,     4'h0, 32'h0,        32'h12345000, 32'h12345000, 5'd7, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00001117, 32'h0100, 32'h0,        32'h0,        4'h0, 32'h100,      32'h1000,     32'h1000,     5'd2, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0020C463, 32'h1018, 32'd3,        32'd4,        4'h2, 32'd3,        32'd4,        32'd8,        5'd0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'hFE000EE3, 32'h101C, 32'd9,        32'd9,        4'h8, 32'd9,        32'd9,        32'hFFFFFFFC, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h0020A463, 32'h1020, 32'd3,        32'd4,        4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h010000EF, 32'h0200, 32'h0,        32'h0,        4'h0, 32'h200,      32'd4,        32'd16,       5'd1, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h00828067, 32'h0300, 32'h40,       32'h0,        4'h0, 32'h300,      32'd4,        32'd8,        5'd0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'h0020A623, 32'h1024, 32'h1000,     32'hDEADBEEF, 4'h0, 32'h1000,     32'd12,       32'd12,       5'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'hFFC0A203, 32'h1028, 32'h1000,     32'h0,        4'h0, 32'h1000,     32'hFFFFFFFC, 32'hFFFFFFFC, 5'd4, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h0000007F, 32'h102C, 32'd1,        32'd2,        4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{32'h40009093, 32'h1030, 32'd1,        32'd2,        4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{32'h0020B1B3, 32'h1034, 32'd6,        32'd8,        4'h3, 32'd6,        32'd8,        32'h0,        5'd3, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{32'h00435293, 32'h1038, 32'hF0,       32'h0,        4'h5, 32'hF0,       32'd4,        32'd4,        5'd5, 3'd0, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive_idle();

        // reset state
        #12;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_pc", out_pc, 32'h0);
        check("reset out_in2", out_in2, 32'h0);
        check("reset out_control", {28'b0, out_control}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready after reset", {31'b0, in_ready}, 32'd1);

        // decode table, back to back with out_ready=1
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive_instr(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d control", i), {28'b0, out_control}, {28'b0, vecs[i].control});
            check($sformatf("v%0d in1", i), out_in1, vecs[i].in1);
            check($sformatf("v%0d in2", i), out_in2, vecs[i].in2);
            check($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d rs2", i), out_rs2, vecs[i].rs2);
            check($sformatf("v%0d pc", i), out_pc, vecs[i].pc);
            check($sformatf("v%0d rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d br_funct", i), {29'b0, out_br_funct}, {29'b0, vecs[i].br_funct});
            check($sformatf("v%0d flags", i), {29'b0, out_is_branch, out_is_jump, out_illegal},
                  {29'b0, vecs[i].is_branch, vecs[i].is_jump, vecs[i].illegal});
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check("drained out_valid", {31'b0, out_valid}, 32'd0);
        check("drained out_pc tag", out_pc, 32'h0);

        // backpressure: out_ready low for 4 cycles while offering 3 instructions
        sent   = 0;
        popped = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc == 4) begin
`ifdef ALU_ISSUE_SKID_EN
                check("stall accepted count", sent, 32'd2);
`else
                check("stall accepted count", sent, 32'd1);
`endif
                check("stall in_ready low", {31'b0, in_ready}, 32'd0);
            end
            out_ready = (cyc >= 4);
            if (sent < 3)
                drive_instr(addi_instr(sent + 1), 32'h2000 + 32'(sent * 4), 32'h0, 32'h0);
            else
                drive_idle();
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bp extra output: got %h expected none", out_in2);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("bp order %0d", popped), out_in2, exp_v);
                end
                popped++;
            end
            if (fire_in)
                exp_q.push_back(32'(sent + 1));
            @(posedge clk);
            if (fire_in)
                sent++;
            if (sent == 3 && popped == 3)
                break;
        end
        check("bp all sent", sent, 32'd3);
        check("bp all received", popped, 32'd3);
        check("bp queue empty", exp_q.size(), 32'd0);
        exp_q.delete();

        // flush coincident with an input transfer into an empty stage
        @(negedge clk);
        out_ready = 1'b1;
        drive_instr(addi_instr(9), 32'h3000, 32'h0, 32'h0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush empty out_valid", {31'b0, out_valid}, 32'd0);

        // flush with an entry held and a new input offered
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_instr(addi_instr(10), 32'h3004, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("pre-flush out_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        drive_instr(addi_instr(11), 32'h3008, 32'h0, 32'h0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush held out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        check("post-flush out_valid", {31'b0, out_valid}, 32'd0);

        // reset asserted mid-stall
        @(negedge clk);
        out_ready = 1'b0;
        drive_instr(addi_instr(12), 32'h4000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("stall out_valid", {31'b0, out_valid}, 32'd1);
        check("stall out_in2", out_in2, 32'd12);
        #2;
        rst = 1'b1;
        #1;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst out_in2", out_in2, 32'h0);
        check("rst out_rd", {27'b0, out_rd}, 32'd0);
        check("rst out_pc", out_pc, 32'h0);
        @(negedge clk);
        drive_idle();
        out_ready = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-rst idle %0d", c), {31'b0, out_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage ahead of the ALU. It is the producer end of the ALU's control/operand interface.
- Takes a fetched RV32I instruction, its PC and register-file read data, and decodes the 4-bit ALU control code.
- Selects the ALU operand pair and generates the immediate.
- Registers the result toward execute with a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TAG, 32'h0, value driven on out_pc while empty/after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- flush  in  1  kill all buffered entries (branch mispredict/trap)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw RV32I instruction
- in_pc  in  32  instruction address
- rs1_data  in  32  register-file read of instr[19:15]
- rs2_data  in  32  register-file read of instr[24:20]
- out_valid  out  1  decoded entry valid toward execute
- out_ready  in  1  execute accepts this cycle
- out_control  out  4  ALU control code
- out_in1  out  32  ALU operand 1
- out_in2  out  32  ALU operand 2
- out_rs2  out  32  store data (rs2_data passthrough)
- out_imm  out  32  sign-extended immediate (branch/jump target use)
- out_pc  out  32  instruction PC
- out_rd  out  5  destination register; 0 for branch/store
- out_br_funct  out  3  funct3 of branch; 0 otherwise
- out_is_branch  out  1  conditional branch
- out_is_jump  out  1  JAL/JALR
- out_illegal  out  1  unsupported opcode/funct

Behaviour:
- Control codes:
  - ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
  - Code 1001 (signed sub) is never issued.
- OP (0110011): control={funct7[5],funct3}. funct7 must be 0000000, or 0100000 only with funct3 000/101; else illegal. in1=rs1, in2=rs2.
- OP-IMM (0010011):
  - control={0,funct3}, except funct3=101 with funct7[5]=1 gives SRA.
  - SLLI/SRLI/SRAI require funct7 0000000/0100000 (0100000 only for 101); else illegal.
  - in1=rs1, in2=I-imm.
- LOAD/STORE: ADD, in1=rs1, in2=I-imm or S-imm.
- BRANCH:
  - BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU.
  - funct3 010/011 illegal.
  - in1=rs1, in2=rs2, out_imm=B-imm.
- LUI: ADD, in1=0, in2=U-imm.
- AUIPC: ADD, in1=pc, in2=U-imm.
- JAL/JALR: ADD, in1=pc, in2=4 (link value), out_imm=J-imm or I-imm.
- Any other opcode: out_illegal=1, control=0000, operands 0. The entry is still issued; execute raises the trap.
- Immediates are sign-extended from instr[31]; B/J LSB is 0.
- Handshake:
  - Transfer occurs when valid&ready on the same edge.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - Latency is 1 cycle from input transfer to out_valid.
- Default buffering (1 entry):
  - in_ready = !out_valid | out_ready (combinational).
  - Throughput is 1 per cycle.
- Flush:
  - Next edge drives out_valid=0 and discards any simultaneous input transfer.
  - in_ready is don't-care during flush, but the input is dropped.
- Reset (any time, including mid-transfer):
  - All outputs 0, out_pc=RESET_PC_TAG, buffered entries cleared.
  - in_ready=1 once rst deasserts (0 while rst=1 under the skid option).

Optional Feature:
- Macro ALU_ISSUE_SKID_EN.
- Defined:
  - 2-entry skid buffer with FSM EMPTY/ONE/FULL.
  - in_ready is registered: in_ready = (state!=FULL).
  - Transitions:
    - EMPTY -in-> ONE
    - ONE -in&!out-> FULL
    - ONE -out&!in-> EMPTY
    - ONE -in&out-> ONE
    - FULL -out-> ONE
  - Order is preserved and full throughput is kept.
  - Flush moves any state to EMPTY.
- Undefined: the 1-entry behaviour above.

Decomposition:
- Package alu_pkg holds:
  - ALU control code localparams.
  - RV32I opcode constants.
  - funct7 constants.
  - The issue-entry struct/field widths.
- Sub-module alu_imm_gen: combinational I/S/B/U/J immediate generator selected by opcode.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, control=0000, in1=5, in2=7, rd=3.
- SUB (0x402081B3) -> control=1000. Same encoding with funct7=0000001 -> out_illegal=1, control=0000.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> control=1101, in2=3, rd=5.
- ADDI x1,x0,-1 (0xFFF00093) -> in2=0xFFFFFFFF. LUI 0x12345 -> in1=0, in2=0x12345000.
- Backpressure: issue 3 instrs with out_ready=0 for 4 cycles:
  - Default: in_ready drops after the first.
  - With skid: drops after the second.
  - Then release -> all issued in order, none lost or duplicated.
- flush coincident with in_valid&in_ready -> out_valid=0 next cycle. rst asserted mid-stall -> all outputs 0 immediately, no entry issued after release.
